// File: rtl/romulus_tbc_sched_pkg.sv
// romulus_tbc_sched_pkg: shared sizes, state encoding and round-constant LFSR step
package romulus_tbc_sched_pkg;
  localparam int NUM_RNDS = 40;
  localparam int RNDS_PER_CLK = 4;
  localparam int CNTW = 6;
  localparam int BUSW = 128;
  localparam int NUM_CLKS = NUM_RNDS / RNDS_PER_CLK;
  localparam int RCW = NUM_CLKS > 1 ? $clog2(NUM_CLKS) : 1;
  typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_ROUND, S_CORRECT, S_STEP, S_DONE} state_t;
  function automatic logic [CNTW-1:0] rc_step(input logic [CNTW-1:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction
endpackage

// File: rtl/romulus_tbc_sched_if.sv
// romulus_tbc_sched_if: command handshake from the mode FSM and datapath control pins
interface romulus_tbc_sched_if;
  import romulus_tbc_sched_pkg::*;
  logic start, cmd_absorb, cmd_iv, cmd_tbc, cmd_cnt_init, cmd_cnt_step;
  logic [BUSW/8-1:0] cmd_decrypt, decrypt;
  logic [7:0] cmd_domain, domain;
  logic busy, done;
  logic sen, senc, xen, xenc, yen, yenc, zen, zenc, zrst, correct_cnt, iv;
  logic [CNTW*RNDS_PER_CLK-1:0] constant;
  modport master (
    output start, cmd_absorb, cmd_iv, cmd_tbc, cmd_cnt_init, cmd_cnt_step, cmd_decrypt, cmd_domain,
    input busy, done, sen, senc, xen, xenc, yen, yenc, zen, zenc, zrst, correct_cnt, iv, decrypt, domain, constant
  );
  modport slave (
    input start, cmd_absorb, cmd_iv, cmd_tbc, cmd_cnt_init, cmd_cnt_step, cmd_decrypt, cmd_domain,
    output busy, done, sen, senc, xen, xenc, yen, yenc, zen, zenc, zrst, correct_cnt, iv, decrypt, domain, constant
  );
endinterface

// File: rtl/romulus_rc_lfsr.sv
// romulus_rc_lfsr: unrolls the round-constant LFSR over one clock's worth of rounds
module romulus_rc_lfsr
  import romulus_tbc_sched_pkg::*;
(
  input  logic [CNTW-1:0]              rc,
  output logic [CNTW*RNDS_PER_CLK-1:0] consts,
  output logic [CNTW-1:0]              rc_nxt
);
  // slice k holds the constant of the k-th round this clock; rc_nxt seeds the next clock
  always_comb begin
    logic [CNTW-1:0] r;
    r = rc;
    consts = '0;
    for (int i = 0; i < RNDS_PER_CLK; i++) begin
      r = rc_step(r);
      consts[i*CNTW +: CNTW] = r;
    end
    rc_nxt = r;
  end
endmodule

// File: rtl/romulus_tbc_sched.sv
// romulus_tbc_sched: sequences absorb, TBC rounds, tweakey correction and counter steps
module romulus_tbc_sched
  import romulus_tbc_sched_pkg::*;
(
  input logic clk,
  input logic rst,
  romulus_tbc_sched_if.slave bus
);
  state_t state, state_nxt;
  logic iv_q, tbc_q, cnt_init_q, cnt_step_q, accept, last_rnd;
  logic [CNTW-1:0] rc, rc_nxt;
  logic [CNTW*RNDS_PER_CLK-1:0] consts;
  logic [RCW-1:0] rnd;
  logic [BUSW/8-1:0] decrypt_q;
  logic [7:0] domain_q;
  romulus_rc_lfsr u_lfsr (.rc(rc), .consts(consts), .rc_nxt(rc_nxt));
  assign accept = state == S_IDLE && bus.start;
  assign last_rnd = rnd == RCW'(NUM_CLKS - 1);
  // state, latched command and round progress; LFSR and round count restart per command
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      {iv_q, tbc_q, cnt_init_q, cnt_step_q} <= '0;
      decrypt_q <= '0;
      domain_q <= '0;
      rc <= '0;
      rnd <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        {iv_q, tbc_q, cnt_init_q, cnt_step_q} <= {bus.cmd_iv, bus.cmd_tbc, bus.cmd_cnt_init, bus.cmd_cnt_step};
        decrypt_q <= bus.cmd_decrypt;
        domain_q <= bus.cmd_domain;
        rc <= '0;
        rnd <= '0;
      end else if (state == S_ROUND) begin
        rc <= rc_nxt;
        rnd <= rnd + 1'b1;
      end
    end
  // next state; a TBC run always ends with the correction cycle, so cnt_step is moot then
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:            state_nxt = !bus.start ? S_IDLE : bus.cmd_absorb ? S_ABSORB :
                                     bus.cmd_tbc ? S_ROUND : bus.cmd_cnt_step ? S_STEP : S_DONE;
      S_ABSORB:          state_nxt = tbc_q ? S_ROUND : cnt_step_q ? S_STEP : S_DONE;
      S_ROUND:           state_nxt = last_rnd ? S_CORRECT : S_ROUND;
      S_CORRECT, S_STEP: state_nxt = S_DONE;
      default:           state_nxt = S_IDLE;
    endcase
  end
  assign bus.busy = state inside {S_ABSORB, S_ROUND, S_CORRECT, S_STEP};
  assign bus.done = state == S_DONE;
  assign bus.sen = state inside {S_ABSORB, S_ROUND};
  assign bus.senc = state == S_ROUND;
  assign bus.xen = state inside {S_ROUND, S_CORRECT};
  assign bus.xenc = state == S_ROUND;
  assign bus.yen = state inside {S_ROUND, S_CORRECT};
  assign bus.yenc = state == S_ROUND;
  assign bus.zen = state inside {S_ROUND, S_CORRECT, S_STEP};
  assign bus.zenc = state == S_ROUND;
  assign bus.zrst = state == S_ABSORB && cnt_init_q;
  assign bus.iv = state == S_ABSORB && iv_q;
  assign bus.correct_cnt = state == S_STEP;
  assign bus.decrypt = decrypt_q;
  assign bus.domain = domain_q;
  assign bus.constant = state == S_ROUND ? consts : '0;
endmodule

// File: tb/tb_romulus_tbc_sched.sv
// tb_romulus_tbc_sched: directed and random commands checked against a per-cycle trace model
module tb_romulus_tbc_sched;
  import romulus_tbc_sched_pkg::*;
  typedef struct packed {
    logic busy, done, sen, senc, xen, xenc, yen, yenc, zen, zenc, zrst, correct_cnt, iv;
    logic [CNTW*RNDS_PER_CLK-1:0] constant;
  } obs_t;
  logic clk = 0, rst = 1;
  int vectors = 0, miscompares = 0;
  logic [BUSW/8-1:0] exp_dec;
  logic [7:0] exp_dom;
  logic [CNTW*RNDS_PER_CLK-1:0] consts[$];
  romulus_tbc_sched_if bus();
  romulus_tbc_sched dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic obs_t sample();
    obs_t o;
    o = {bus.busy, bus.done, bus.sen, bus.senc, bus.xen, bus.xenc, bus.yen, bus.yenc, bus.zen, bus.zenc,
         bus.zrst, bus.correct_cnt, bus.iv, bus.constant};
    return o;
  endfunction
  function automatic logic [5:0] rc_of(input int r);
    int v;
    v = 0;
    for (int i = 0; i < r; i++) v = ((v * 2) % 64) + ((((v >> 5) ^ (v >> 4)) & 1) ^ 1);
    return 6'(v);
  endfunction
  function automatic logic [23:0] pk(input logic [5:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic chk_cycle(input string tag, input obs_t e);
    obs_t o;
    o = sample();
    consts.push_back(o.constant);
    chk({tag, "_ctl"}, 64'(o), 64'(e));
    chk({tag, "_dom"}, 64'(bus.domain), 64'(exp_dom));
    chk({tag, "_dec"}, 64'(bus.decrypt), 64'(exp_dec));
  endtask
  task automatic run_cmd(input logic a, ivb, t, ci, cs, input logic [BUSW/8-1:0] dec,
                         input logic [7:0] dom, input int poke, input int rst_at);
    obs_t q[$];
    obs_t e;
    if (a) begin
      e = '0; e.busy = 1; e.sen = 1; e.zrst = ci; e.iv = ivb;
      q.push_back(e);
    end
    if (t) begin
      for (int j = 0; j < NUM_CLKS; j++) begin
        e = '0; e.busy = 1;
        {e.sen, e.senc, e.xen, e.xenc, e.yen, e.yenc, e.zen, e.zenc} = '1;
        for (int k = 0; k < RNDS_PER_CLK; k++) e.constant[k*CNTW +: CNTW] = rc_of(j * RNDS_PER_CLK + k + 1);
        q.push_back(e);
      end
      e = '0; e.busy = 1; e.xen = 1; e.yen = 1; e.zen = 1;
      q.push_back(e);
    end else if (cs) begin
      e = '0; e.busy = 1; e.zen = 1; e.correct_cnt = 1;
      q.push_back(e);
    end
    e = '0; e.done = 1;
    q.push_back(e);
    {bus.cmd_absorb, bus.cmd_iv, bus.cmd_tbc, bus.cmd_cnt_init, bus.cmd_cnt_step} = {a, ivb, t, ci, cs};
    bus.cmd_decrypt = dec;
    bus.cmd_domain = dom;
    bus.start = 1;
    @(posedge clk);
    #1;
    bus.start = 0;
    bus.cmd_domain = 8'($urandom);
    bus.cmd_decrypt = 16'($urandom);
    exp_dom = dom;
    exp_dec = dec;
    consts.delete();
    for (int c = 0; c < q.size(); c++) begin
      @(negedge clk);
      chk_cycle($sformatf("cyc%0d", c), q[c]);
      if (c == rst_at) begin
        #1 rst = 1;
        #1;
        exp_dom = 0;
        exp_dec = 0;
        chk("async_rst_ctl", 64'(sample()), 64'(0));
        chk("async_rst_dom", 64'(bus.domain), 64'(0));
        chk("async_rst_dec", 64'(bus.decrypt), 64'(0));
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk_cycle("post_rst_idle", '0);
        return;
      end
      if (c == poke && c < q.size() - 1) begin
        bus.start = 1;
        bus.cmd_domain = ~dom;
        bus.cmd_decrypt = ~dec;
        {bus.cmd_absorb, bus.cmd_tbc, bus.cmd_cnt_step} = 3'b111;
      end
      if (c == poke + 1) bus.start = 0;
    end
    bus.start = 0;
    @(negedge clk);
    chk_cycle("idle_after", '0);
  endtask
  initial begin
    bus.start = 0;
    {bus.cmd_absorb, bus.cmd_iv, bus.cmd_tbc, bus.cmd_cnt_init, bus.cmd_cnt_step} = '0;
    bus.cmd_decrypt = '0;
    bus.cmd_domain = '0;
    exp_dom = 0;
    exp_dec = 0;
    repeat (2) @(negedge clk);
    chk_cycle("reset", '0);
    rst = 0;
    @(negedge clk);
    chk_cycle("idle0", '0);
    run_cmd(1, 0, 1, 0, 0, 16'h0000, 8'h08, -1, -1);
    chk("rc_clk1", 64'(consts[1]), 64'(pk(6'h01, 6'h03, 6'h07, 6'h0F)));
    chk("rc_clk2", 64'(consts[2]), 64'(pk(6'h1F, 6'h3E, 6'h3D, 6'h3B)));
    run_cmd(0, 0, 0, 0, 1, 16'hA5C3, 8'h1F, -1, -1);
    run_cmd(1, 1, 0, 1, 0, 16'h00FF, 8'h42, -1, -1);
    run_cmd(0, 0, 0, 0, 0, 16'h1234, 8'h99, -1, -1);
    run_cmd(1, 0, 1, 0, 1, 16'hF00F, 8'h2C, 3, -1);
    run_cmd(1, 0, 1, 1, 0, 16'hBEEF, 8'h55, -1, 5);
    run_cmd(0, 0, 1, 0, 0, 16'h0F0F, 8'h0D, -1, -1);
    chk("rc_after_rst", 64'(consts[0]), 64'(pk(6'h01, 6'h03, 6'h07, 6'h0F)));
    repeat (30)
      run_cmd(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              16'($urandom), 8'($urandom), int'($urandom_range(0, 4)) - 1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
